// File: rtl/uart_16550_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_16550_tx_serializer
//
// Purpose:
//   Transmit serializer of a 16550-style UART. It sits directly behind the Tx
//   FIFO. Each character is popped from the FIFO and shifted onto SOUT as one
//   frame: start bit, 5-8 data bits LSB first, optional parity, then 1, 1.5
//   or 2 stop bits. Bit timing comes from an external 16x baud tick. The
//   block also produces the LSR transmitter-empty (TEMT) status.
//
// Build option:
//   UART_TX_LOOPBACK_EN - adds MCR_Loopback_i / Loop_SOUT_o. In loopback,
//   SOUT_o is held high and the serial stream (including break) is sent to
//   Loop_SOUT_o for the receiver instead.
//
// Parameters:
//   TICKS_PER_BIT      baud-tick pulses per bit time (even, >= 4)
//
// Ports:
//   WBs_CLK_i          fabric clock, the only clock
//   WBs_RST_i          synchronous active-high reset
//   Baud_16x_Tick_i    one-cycle enable pulse at 16x the baud rate
//   LCR_Word_Len_i     00=5, 01=6, 10=7, 11=8 data bits
//   LCR_Stop_Bits_i    0=1 stop bit; 1=2 stop bits (1.5 for 5-bit words)
//   LCR_Parity_En_i    parity bit enable
//   LCR_Even_Parity_i  1=even, 0=odd parity
//   LCR_Stick_Parity_i parity bit forced to ~LCR_Even_Parity_i
//   LCR_Break_i        force the serial line low
//   Tx_FIFO_Empty_i    Tx FIFO empty flag
//   Tx_FIFO_DAT_i      head-of-FIFO data (first-word fall-through)
//   MCR_Loopback_i     loopback select (UART_TX_LOOPBACK_EN only)
//   Loop_SOUT_o        loopback serial stream (UART_TX_LOOPBACK_EN only)
//   Tx_FIFO_Pop_o      one-cycle pop strobe, coincident with the load
//   SOUT_o             registered serial output, idle high
//   Tx_Shift_Empty_o   TEMT: FIFO empty and serializer idle (registered)
//   Tx_Busy_o          frame in progress
// -----------------------------------------------------------------------------
module uart_16550_tx_serializer #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       WBs_CLK_i,
  input  logic       WBs_RST_i,
  input  logic       Baud_16x_Tick_i,
  input  logic [1:0] LCR_Word_Len_i,
  input  logic       LCR_Stop_Bits_i,
  input  logic       LCR_Parity_En_i,
  input  logic       LCR_Even_Parity_i,
  input  logic       LCR_Stick_Parity_i,
  input  logic       LCR_Break_i,
  input  logic       Tx_FIFO_Empty_i,
  input  logic [7:0] Tx_FIFO_DAT_i,
`ifdef UART_TX_LOOPBACK_EN
  input  logic       MCR_Loopback_i,
  output logic       Loop_SOUT_o,
`endif
  output logic       Tx_FIFO_Pop_o,
  output logic       SOUT_o,
  output logic       Tx_Shift_Empty_o,
  output logic       Tx_Busy_o
);

  // The longest state (two stop bits) needs counts up to 2*TICKS_PER_BIT-1.
  localparam int CW = $clog2(2 * TICKS_PER_BIT);

  localparam logic [CW-1:0] LAST_ONE_BIT = CW'(TICKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_ONE_HALF = CW'(TICKS_PER_BIT + (TICKS_PER_BIT / 2) - 1);
  localparam logic [CW-1:0] LAST_TWO_BITS = CW'((2 * TICKS_PER_BIT) - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   tick_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [1:0]      wlen_q;
  logic            stop2_q;
  logic            par_en_q;
  logic            par_bit_q;
  logic            sout_q;
  logic            temt_q;

  logic [CW-1:0]   bit_last_s;
  logic            bit_done_s;
  logic            last_data_s;
  logic            serial_s;
  logic            stream_s;
  logic            load_s;

  // Parity of the data bits inside the word length. The bit is computed once
  // at load time from the latched framing, so later LCR writes cannot alter
  // the frame that is already on the line.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [1:0] wlen,
                                       input logic       even,
                                       input logic       stick);
    logic [7:0] mask;
    logic       x;
    case (wlen)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    x = ^(data & mask);
    if (stick) begin
      calc_parity = ~even;
    end else begin
      calc_parity = even ? x : ~x;
    end
  endfunction

  // Bit-time bookkeeping: where the current state ends and whether this
  // cycle closes it.
  always_comb begin
    bit_last_s = LAST_ONE_BIT;
    if (state_q == ST_STOP) begin
      if (!stop2_q) begin
        bit_last_s = LAST_ONE_BIT;
      end else if (wlen_q == 2'b00) begin
        bit_last_s = LAST_ONE_HALF;
      end else begin
        bit_last_s = LAST_TWO_BITS;
      end
    end else begin
      bit_last_s = LAST_ONE_BIT;
    end
    bit_done_s  = Baud_16x_Tick_i && (tick_cnt_q == bit_last_s);
    // bit_cnt_q counts from 0, so the last data bit is word length - 1.
    last_data_s = (bit_cnt_q == ({1'b0, wlen_q} + 3'd4));
  end

  // State register.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!Tx_FIFO_Empty_i) state_d = ST_START;
        else                  state_d = ST_IDLE;
      end
      ST_START: begin
        if (bit_done_s) state_d = ST_DATA;
        else            state_d = ST_START;
      end
      ST_DATA: begin
        if (bit_done_s && last_data_s) state_d = par_en_q ? ST_PARITY : ST_STOP;
        else                           state_d = ST_DATA;
      end
      ST_PARITY: begin
        if (bit_done_s) state_d = ST_STOP;
        else            state_d = ST_PARITY;
      end
      ST_STOP: begin
        // Chain straight into the next frame when more data is waiting.
        if (bit_done_s) state_d = Tx_FIFO_Empty_i ? ST_IDLE : ST_START;
        else            state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: serial bit for the current state and the load/pop strobe.
  always_comb begin
    serial_s = 1'b1;
    case (state_q)
      ST_START:  serial_s = 1'b0;
      ST_DATA:   serial_s = shift_q[0];
      ST_PARITY: serial_s = par_bit_q;
      default:   serial_s = 1'b1;
    endcase
    // Load (and pop) from IDLE, or at the very end of STOP. Gated by reset so
    // a reset cycle never consumes a FIFO entry.
    if (!WBs_RST_i && !Tx_FIFO_Empty_i &&
        ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done_s))) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    stream_s = LCR_Break_i ? 1'b0 : serial_s;
  end

  // Datapath: tick/bit counters, shift register, latched framing, outputs.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      wlen_q     <= 2'b00;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      sout_q     <= 1'b1;
      temt_q     <= 1'b1;
    end else begin
      // The first tick after the load begins the START bit time.
      if (load_s || (state_q == ST_IDLE)) begin
        tick_cnt_q <= '0;
      end else if (bit_done_s) begin
        tick_cnt_q <= '0;
      end else if (Baud_16x_Tick_i) begin
        tick_cnt_q <= tick_cnt_q + CW'(1);
      end else begin
        tick_cnt_q <= tick_cnt_q;
      end

      if (load_s) begin
        shift_q   <= Tx_FIFO_DAT_i;
        bit_cnt_q <= 3'd0;
        wlen_q    <= LCR_Word_Len_i;
        stop2_q   <= LCR_Stop_Bits_i;
        par_en_q  <= LCR_Parity_En_i;
        par_bit_q <= calc_parity(Tx_FIFO_DAT_i, LCR_Word_Len_i,
                                 LCR_Even_Parity_i, LCR_Stick_Parity_i);
      end else if ((state_q == ST_DATA) && bit_done_s) begin
        shift_q   <= {1'b0, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end else begin
        shift_q   <= shift_q;
        bit_cnt_q <= bit_cnt_q;
      end

`ifdef UART_TX_LOOPBACK_EN
      sout_q <= MCR_Loopback_i ? 1'b1 : stream_s;
`else
      sout_q <= stream_s;
`endif
      temt_q <= Tx_FIFO_Empty_i && (state_q == ST_IDLE);
    end
  end

`ifdef UART_TX_LOOPBACK_EN
  logic loop_q;

  // Loopback copy of the stream; idles high when loopback is off.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      loop_q <= 1'b1;
    end else begin
      loop_q <= MCR_Loopback_i ? stream_s : 1'b1;
    end
  end

  assign Loop_SOUT_o = loop_q;
`endif

  assign Tx_FIFO_Pop_o    = load_s;
  assign SOUT_o           = sout_q;
  assign Tx_Shift_Empty_o = temt_q;
  assign Tx_Busy_o        = (state_q != ST_IDLE);

endmodule
